test_mailbox: RTL

Memory-mapped test-completion responder on the core's data-memory port (M stage), sitting alongside data memory in `top`. It is the far end of the bench/processor conversation. Test programs store pass/fail codes, console characters and signature words to it. It buffers characters in a FIFO drained by the bench over a valid/ready stream, and exposes done, pass and fail status plus a watchdog timeout so the bench needs no fixed `#delay` or hierarchical register peeks.

---
 rtl/test_mailbox.sv | 138 +++++++++++++
 1 files changed

// File: rtl/test_mailbox.sv
// Memory-mapped test mailbox: pass/fail/timeout status, a character FIFO drained
// over valid/ready, a rotating-XOR signature and a RUN-cycle counter.
module test_mailbox #(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        hit,
  output logic [31:0] ReadDataMbox,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_code,
  output logic        timeout,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [31:0]        sig_q, sig_d;
  logic [31:0]        fail_code_q, fail_code_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic wr, wr_tohost, wr_char, wr_sig;
  logic full, empty, pop, push;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^ALUResultM[1:0];

  assign hit       = (ALUResultM[31:4] == BASE_ADDR[31:4]);
  assign wr        = MemWriteM & hit;
  assign wr_tohost = wr & (ALUResultM[3:2] == 2'd0);
  assign wr_char   = wr & (ALUResultM[3:2] == 2'd1);
  assign wr_sig    = wr & (ALUResultM[3:2] == 2'd2);

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = ~empty & char_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push  = wr_char & (~full | pop);

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    sig_d       = sig_q;
    fail_code_d = fail_code_q;
    overflow_d  = overflow_q | (wr_char & ~push);
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    if (state_q == S_RUN) begin
      if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
      if (wr_sig) sig_d = {sig_q[30:0], sig_q[31]} ^ WriteDataM;
      // TOHOST write outranks a watchdog expiry in the same cycle.
      if (wr_tohost && WriteDataM == 32'd1) begin
        state_d = S_PASS;
      end else if (wr_tohost && WriteDataM != 32'd0) begin
        state_d     = S_FAIL;
        fail_code_d = WriteDataM;
      end else if (TIMEOUT_CYCLES != 32'd0 && cycles_q == TIMEOUT_CYCLES - 32'd1) begin
        state_d = S_TIMEOUT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      cycles_q    <= '0;
      sig_q       <= '0;
      fail_code_q <= '0;
      overflow_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      sig_q       <= sig_d;
      fail_code_q <= fail_code_d;
      overflow_q  <= overflow_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: the storage array is not reset; emptiness is tracked by count_q and
  // char_data is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= WriteDataM[7:0];
  end

  always_comb begin
    ReadDataMbox = 32'd0;
    if (hit) begin
      case (ALUResultM[3:2])
        2'd0:    ReadDataMbox = {30'd0, state_q};
        2'd1:    ReadDataMbox = {22'd0, overflow_q, full, 8'(count_q)};
        2'd2:    ReadDataMbox = sig_q;
        default: ReadDataMbox = cycles_q;
      endcase
    end
  end

  assign char_valid = ~empty;
  assign char_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign done       = (state_q != S_RUN);
  assign pass       = (state_q == S_PASS);
  assign timeout    = (state_q == S_TIMEOUT);
  assign fail_code  = fail_code_q;
  assign overflow   = overflow_q;

endmodule
